fphub_result_fifo: RTL
======================

FPHUB_RESULT_FIFO -- requirements
Module: fphub_result_fifo

Interface
REQ-001 The block SHALL have parameter WIDTH, default 16, meaning the result word width in bits (E+M+1 of the HUB format).
REQ-002 The block SHALL have parameter DEPTH, default 4, meaning the number of entries; legal values are powers of two, 2 to 16.
REQ-003 The block SHALL have port clk_i, input, 1 bit, the single clock; all state changes on its rising edge.
REQ-004 The block SHALL have port rst_ni, input, 1 bit, asynchronous active-low reset.
REQ-005 The block SHALL have port flush_i, input, 1 bit, synchronous discard of all stored entries.
REQ-006 The block SHALL have port in_valid_i, input, 1 bit, upstream result valid (driven by the HUB adder wrapper's out_valid_o).
REQ-007 The block SHALL have port in_ready_o, output, 1 bit, entry available.
REQ-008 The block SHALL have port result_i, input, WIDTH bits, HUB result word.
REQ-009 The block SHALL have port status_i, input, 5 bits, fpnew status flags {NV,DZ,OF,UF,NX}.
REQ-010 The block SHALL have port out_valid_o, output, 1 bit, head entry valid.
REQ-011 The block SHALL have port out_ready_i, input, 1 bit, downstream accepts.
REQ-012 The block SHALL have port result_o, output, WIDTH bits, head result.
REQ-013 The block SHALL have port status_o, output, 5 bits, head status.
REQ-014 The block SHALL have port usage_o, output, $clog2(DEPTH)+1 bits, current occupancy 0..DEPTH.

Function
REQ-015 Push SHALL occur on a clock edge with in_valid_i=1 and in_ready_o=1; pop SHALL occur with out_valid_o=1 and out_ready_i=1.
REQ-016 in_ready_o SHALL equal (usage_o != DEPTH) and depend only on registered state, with no combinational path from out_ready_i.
REQ-017 out_valid_o SHALL equal (usage_o != 0) and depend only on registered state, with no combinational path from in_valid_i.
REQ-018 The latency SHALL be 1 cycle: a word pushed into an empty FIFO appears on result_o/status_o with out_valid_o=1 in the next cycle, with no same-cycle bypass.
REQ-019 Ordering SHALL be strict FIFO; result_o and status_o SHALL be the oldest stored entry and remain stable while out_valid_o=1 and out_ready_i=0.
REQ-020 When the FIFO is empty, result_o and status_o SHALL be driven to all zeros.
REQ-021 The block SHALL keep read and write pointers of $clog2(DEPTH) bits that wrap modulo DEPTH, plus an occupancy counter; a simultaneous push and pop SHALL advance both pointers and leave usage_o unchanged.
REQ-022 When full, in_ready_o=0, so a same-cycle pop SHALL NOT admit a push; the push is accepted on the following cycle.
REQ-023 When empty, a push SHALL NOT be popped in the same cycle.
REQ-024 flush_i=1 SHALL zero the pointers and usage_o at the next edge, take priority over a same-cycle push and pop, and drop the pushed word.
REQ-025 Storage contents SHALL NOT need clearing on flush or reset; only pointers, counter and sticky register are cleared.

Reset
REQ-026 While rst_ni=0, asynchronously: pointers=0, usage_o=0, in_ready_o=1, out_valid_o=0, result_o=0, status_o=0, sticky_status_o=0.
REQ-027 Reset asserted mid-transfer SHALL discard all entries; the first push after release SHALL be accepted normally.

Configuration
REQ-028 With macro FPHUB_RESULT_FIFO_STICKY_EN defined, the block SHALL add output sticky_status_o (5 bits) equal to the bitwise OR of status_o over all popped entries since reset or flush, updated at the pop edge.
REQ-029 With FPHUB_RESULT_FIFO_STICKY_EN defined, flush SHALL clear sticky_status_o, taking priority over a same-cycle pop.
REQ-030 Without FPHUB_RESULT_FIFO_STICKY_EN, the port and its register SHALL be absent and all other behaviour SHALL be identical.

Verification
REQ-031 Scenario: DEPTH=4; push 0x3C00 with out_ready_i=0 -> next cycle out_valid_o=1, result_o=0x3C00, usage_o=1.
REQ-032 Scenario: push 0x0001..0x0004 with out_ready_i=0 -> usage_o=4, in_ready_o=0; a fifth word 0x0005 held valid is not accepted; one pop -> 0x0005 accepted the next cycle; pops return 0x0002,0x0003,0x0004,0x0005.
REQ-033 Scenario: steady push and pop each cycle for 10 words across pointer wrap -> usage_o stays 1, output order is preserved, there are no bubbles after the first.
REQ-034 Scenario: usage_o=3, flush_i=1 with in_valid_i=1 and out_ready_i=1 -> next cycle usage_o=0, out_valid_o=0, result_o=0, and the pushed word is lost.
REQ-035 Scenario: rst_ni driven low between clock edges with usage_o=2 -> outputs reach reset values immediately, without waiting for an edge.
REQ-036 Scenario: STICKY_EN defined; pop entries with status 5'b00001 then 5'b10000 -> sticky_status_o=5'b10001; flush -> 5'b00000.

Source files
------------

// File: rtl/fphub_result_fifo.sv
// Result FIFO behind the HUB adder: registered ready/valid with 1-cycle latency, zeroed head when empty.
// Optional FPHUB_RESULT_FIFO_STICKY_EN adds sticky_status_o, the OR of popped status flags.
module fphub_result_fifo #(
    parameter int WIDTH = 16,
    parameter int DEPTH = 4
) (
    input  logic                       clk_i,
    input  logic                       rst_ni,
    input  logic                       flush_i,
    input  logic                       in_valid_i,
    output logic                       in_ready_o,
    input  logic [WIDTH-1:0]           result_i,
    input  logic [4:0]                 status_i,
    output logic                       out_valid_o,
    input  logic                       out_ready_i,
    output logic [WIDTH-1:0]           result_o,
    output logic [4:0]                 status_o,
`ifdef FPHUB_RESULT_FIFO_STICKY_EN
    output logic [4:0]                 sticky_status_o,
`endif
    output logic [$clog2(DEPTH):0]     usage_o
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam logic [CNT_W-1:0] FULL = CNT_W'(DEPTH);

    typedef struct packed {
        logic [4:0]       status;
        logic [WIDTH-1:0] result;
    } entry_t;

    entry_t               mem [DEPTH];
    logic [PTR_W-1:0]     wr_ptr, rd_ptr;
    logic [CNT_W-1:0]     usage;
    logic                 push, pop;
    entry_t               head;

    // Handshake flags come only from the occupancy register, never from the peer's strobe.
    assign in_ready_o  = (usage != FULL);
    assign out_valid_o = (usage != '0);
    assign usage_o     = usage;

    assign push = in_valid_i & in_ready_o & ~flush_i;
    assign pop  = out_valid_o & out_ready_i & ~flush_i;

    assign head     = mem[rd_ptr];
    assign result_o = out_valid_o ? head.result : '0;
    assign status_o = out_valid_o ? head.status : '0;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            usage  <= '0;
        end else if (flush_i) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            usage  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + PTR_W'(1);
            if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
            case ({push, pop})
                2'b10:   usage <= usage + CNT_W'(1);
                2'b01:   usage <= usage - CNT_W'(1);
                default: usage <= usage;
            endcase
        end
    end

    // Storage is never cleared; the zeroed head covers the empty case.
    always_ff @(posedge clk_i) begin
        if (push) mem[wr_ptr] <= '{status: status_i, result: result_i};
    end

`ifdef FPHUB_RESULT_FIFO_STICKY_EN
    logic [4:0] sticky_q;
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni)      sticky_q <= '0;
        else if (flush_i) sticky_q <= '0;
        else if (pop)     sticky_q <= sticky_q | head.status;
    end
    assign sticky_status_o = sticky_q;
`endif

endmodule
